sequenceur_mul_div: RTL and testbench
=====================================

Name: sequenceur_mul_div

Overview:
- Multi-cycle controller that computes RV32M-style multiply and unsigned divide/remainder by sequencing the shared execute-stage ALU.
- Add, subtract and unsigned-compare steps are issued through the ALU's operation/operand inputs.
- Sits beside the execute stage. While busy it owns the ALU via alu_req and stalls the pipeline; when idle the pipeline drives the ALU.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  3  000 MUL (low word), 001 MULHU (high word, unsigned), 010 DIVU, 011 REMU, 100 DIV, 101 REM (100/101 only with the optional feature).
- opa  in  32  rs1 value (multiplicand / dividend).
- opb  in  32  rs2 value (multiplier / divisor).
- flush  in  1  pipeline flush; aborts the current operation.
- busy  out  1  high from the cycle after start acceptance until done; pipeline stall request.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  final value; held until the next accepted start.
- alu_req  out  1  high while the sequencer owns the ALU.
- alu_operation  out  5  ALU opcode: 00000 add, 01000 sub, 10111 unsigned greater-or-equal.
- alu_rs1  out  32  ALU operand 1; drives both the signed and unsigned operand-1 inputs.
- alu_rs2  out  32  ALU operand 2; drives both the signed and unsigned operand-2 inputs.
- alu_source  out  1  always 0 (register operand).
- alu_resultat  in  32  ALU result, combinational, same cycle.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - busy, done, alu_req, alu_source = 0.
  - result = 0, alu_operation = 00000, alu_rs1 = alu_rs2 = 0.
  - All internal registers cleared.
- Reset mid-operation: immediate abort to IDLE; no done.
- States: IDLE, MUL_ADD, DIV_CMP, DIV_SUB, FIXUP (feature only), DONE.
- IDLE: start=1 latches op, opa and opb, clears the counter, sets busy.
  - MUL/MULHU -> MUL_ADD.
  - DIVU/REMU with opb != 0 -> DIV_CMP.
  - opb == 0 -> DONE directly: DIVU result 0xFFFFFFFF, REMU result opa.
  - op 1xx without the feature -> DONE, result 0.
- MUL_ADD, 32 cycles, one bit per cycle, LSB first:
  - ALU computes acc_hi + multiplicand (00000).
  - If the current multiplier bit is 1, the sum is taken; otherwise acc_hi is kept.
  - carry = (alu_resultat < acc_hi), unsigned, using a local comparator, used only when the sum is taken.
  - {carry, acc_hi, acc_lo} shifts right 1; the multiplier's low bit is consumed into acc_lo.
  - After count 31 -> DONE.
  - MUL returns acc_lo; MULHU returns acc_hi.
- DIV_CMP / DIV_SUB, 2 cycles per bit, 32 bits, restoring algorithm:
  - DIV_CMP: shift {rem, quot} left 1; msb_out is the bit shifted out of rem.
    - ALU issues 10111 with operands (shifted rem, divisor).
  - DIV_SUB: ALU issues 01000 (shifted rem - divisor).
    - If msb_out or the previous ge result is 1: rem=alu_resultat and quot bit=1.
    - Otherwise rem is unchanged and quot bit=0.
  - After bit 31 -> DONE.
- Latency, counted from the start-sample edge (cycle 0):
  - MUL/MULHU: done at cycle 33.
  - DIVU/REMU: done at cycle 65.
  - Divide-by-zero or illegal op: done at cycle 1.
- DONE: result registered, done=1 for 1 cycle, busy=0 in the same cycle, alu_req=0, -> IDLE.
  - A start in the cycle after DONE is accepted normally.
- alu_req = 1 in MUL_ADD, DIV_CMP, DIV_SUB and FIXUP only. Outputs are registered except the alu_* drive, which is decoded from state.
- start while busy: ignored, no queueing.
- flush: returns to IDLE on the next edge; no done, result unchanged.
  - flush has priority over start in the same cycle.
  - flush coincident with DONE: done is still suppressed and result is not updated.
- Operand inputs are not sampled after acceptance; they may change freely.

Optional Feature:
- Macro SIGNED_MULDIV_EN.
- Defined: op 100 DIV and 101 REM are legal.
  - At start, operand magnitudes are latched using the sequencer's local negate.
  - After the unsigned iterations, FIXUP (1 cycle) negates the result through the ALU (01000, 0 - x) when required: quotient negative iff the signs differ; remainder takes the dividend's sign.
  - Signed latency: 66 cycles.
  - Divide by zero: DIV returns 0xFFFFFFFF and REM returns opa, at cycle 1.
  - Overflow 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000 and REM returns 0, at cycle 1.
- Undefined: no FIXUP state or sign logic; op 1xx gives result 0 and done at cycle 1.

Test Plan:
- Reset released, then MUL opa=7 opb=6 -> done at cycle 33, result=0x0000002A; alu_req high cycles 1-32; busy low in the done cycle.
- MULHU opa=opb=0xFFFFFFFF -> result=0xFFFFFFFE at cycle 33; MUL with the same operands -> 0x00000001.
- DIVU 100/7 -> 0x0000000E at cycle 65; REMU 100/7 -> 0x00000002; DIVU 0xFFFFFFFF/0x80000000 -> 1 (exercises msb_out).
- DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5; alu_req never asserted.
- MUL started, second start at cycle 10 -> ignored; flush at cycle 20 -> IDLE at cycle 21, no done, result unchanged; reset_n pulsed low mid-DIVU -> all outputs 0 immediately.
- With SIGNED_MULDIV_EN: DIV -7/2 -> 0xFFFFFFFD at cycle 66; REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000 at cycle 1. Without the macro: op=100 -> result 0 at cycle 1.

Source files
------------

// File: rtl/sequenceur_mul_div.sv
// sequenceur_mul_div
//   Multi-cycle RV32M multiply / unsigned divide sequencer. It borrows the
//   shared execute-stage ALU for its add, subtract and unsigned-compare steps.
//   While it works it raises alu_req, which steers the ALU operand muxes to
//   this block, and it raises busy, which stalls the pipeline.
//
//   Optional build macro: SIGNED_MULDIV_EN enables signed DIV/REM (op 100/101).
//   This path latches operand magnitudes and adds a one-cycle FIXUP state that
//   negates the result through the ALU.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   start, op, opa, opb request pulse, opcode, rs1/rs2 values (sampled in IDLE)
//   flush               abort the current operation (no done, result kept)
//   busy, done, result  stall request, one-cycle completion pulse, result
//   alu_req             sequencer owns the ALU
//   alu_operation       00000 add, 01000 sub, 10111 unsigned >=
//   alu_rs1, alu_rs2    ALU operands (feed both signed and unsigned inputs)
//   alu_source          always 0 (register operand)
//   alu_resultat        combinational ALU result, same cycle
module sequenceur_mul_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  output logic [4:0]      alu_operation,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic            alu_source,
  input  logic [XLEN-1:0] alu_resultat
);

  localparam logic [4:0]       ALU_ADD  = 5'b00000;
  localparam logic [4:0]       ALU_SUB  = 5'b01000;
  localparam logic [4:0]       ALU_GEU  = 5'b10111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  typedef enum logic [2:0] {
    IDLE,
    MUL_ADD,
    DIV_CMP,
    DIV_SUB,
`ifdef SIGNED_MULDIV_EN
    FIXUP,
`endif
    DONE
  } state_t;

  state_t state, state_n;

  // hi/lo: acc_hi/acc_lo while multiplying (acc_lo starts as the multiplier),
  // rem/quot while dividing (quot starts as the dividend).
  // opnd: multiplicand or divisor.
  logic [XLEN-1:0]  hi, hi_n, lo, lo_n, opnd, opnd_n, res_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sel, sel_n;   // op[0]: high word / remainder selected
  logic             msb, msb_n;   // bit shifted out of rem in DIV_CMP
  logic             ge, ge_n;     // ALU compare result from DIV_CMP
  logic             busy_n;

  // Shifted partial remainder: {rem, quot} << 1, upper half.
  logic [XLEN-1:0] hi_sh;
  assign hi_sh = {hi[XLEN-2:0], lo[XLEN-1]};

  // Multiply step helpers.
  logic            take, carry;
  logic [XLEN-1:0] hi_sel;

`ifdef SIGNED_MULDIV_EN
  logic            sgn, sgn_n, neg_q, neg_q_n, neg_r, neg_r_n;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            ovf;
  assign abs_a = opa[XLEN-1] ? (~opa + 1'b1) : opa;
  assign abs_b = opb[XLEN-1] ? (~opb + 1'b1) : opb;
  assign ovf   = (opa == (XLEN'(1) << (XLEN-1))) && (opb == '1);
`endif

  // ALU drive is decoded from state so it follows ownership immediately.
  assign alu_source = 1'b0;
  always_comb begin
    alu_req       = 1'b0;
    alu_operation = ALU_ADD;
    alu_rs1       = '0;
    alu_rs2       = '0;
    case (state)
      MUL_ADD: begin
        alu_req = 1'b1; alu_operation = ALU_ADD; alu_rs1 = hi;    alu_rs2 = opnd;
      end
      DIV_CMP: begin
        alu_req = 1'b1; alu_operation = ALU_GEU; alu_rs1 = hi_sh; alu_rs2 = opnd;
      end
      DIV_SUB: begin
        alu_req = 1'b1; alu_operation = ALU_SUB; alu_rs1 = hi;    alu_rs2 = opnd;
      end
`ifdef SIGNED_MULDIV_EN
      FIXUP: begin
        alu_req = 1'b1; alu_operation = ALU_SUB; alu_rs1 = '0;    alu_rs2 = sel ? hi : lo;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    hi_n    = hi;
    lo_n    = lo;
    opnd_n  = opnd;
    cnt_n   = cnt;
    sel_n   = sel;
    msb_n   = msb;
    ge_n    = ge;
    res_n   = result;
    take    = lo[0];
    carry   = (alu_resultat < hi);
    hi_sel  = hi;
`ifdef SIGNED_MULDIV_EN
    sgn_n   = sgn;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          sel_n = op[0];
          cnt_n = '0;
          casez (op)
            3'b00?: begin
              hi_n = '0; lo_n = opb; opnd_n = opa; state_n = MUL_ADD;
            end
            3'b01?: begin
              if (opb == '0) begin
                res_n = op[0] ? opa : '1; state_n = DONE;
              end else begin
                hi_n = '0; lo_n = opa; opnd_n = opb; state_n = DIV_CMP;
              end
`ifdef SIGNED_MULDIV_EN
              sgn_n = 1'b0;
`endif
            end
`ifdef SIGNED_MULDIV_EN
            3'b10?: begin
              if (opb == '0) begin
                res_n = op[0] ? opa : '1; state_n = DONE;
              end else if (ovf) begin
                res_n = op[0] ? '0 : opa; state_n = DONE;
              end else begin
                hi_n    = '0; lo_n = abs_a; opnd_n = abs_b; state_n = DIV_CMP;
                sgn_n   = 1'b1;
                neg_q_n = opa[XLEN-1] ^ opb[XLEN-1];
                neg_r_n = opa[XLEN-1];
              end
            end
`endif
            default: begin
              res_n = '0; state_n = DONE;
            end
          endcase
        end
      end
      MUL_ADD: begin
        // Add only when the multiplier bit is set; the carry out of the
        // 32-bit add is recovered by an unsigned wrap check.
        hi_sel = take ? alu_resultat : hi;
        hi_n   = {take & carry, hi_sel[XLEN-1:1]};
        lo_n   = {hi_sel[0], lo[XLEN-1:1]};
        cnt_n  = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          res_n   = sel ? hi_n : lo_n;
          state_n = DONE;
        end
      end
      DIV_CMP: begin
        hi_n    = hi_sh;
        lo_n    = {lo[XLEN-2:0], 1'b0};
        msb_n   = hi[XLEN-1];
        ge_n    = alu_resultat[0];
        state_n = DIV_SUB;
      end
      DIV_SUB: begin
        // A set msb_out means the true 33-bit remainder exceeds any divisor;
        // the 32-bit subtract still yields the right remainder.
        if (msb || ge) begin
          hi_n = alu_resultat;
          lo_n = {lo[XLEN-1:1], 1'b1};
        end
        cnt_n   = cnt + 1'b1;
        state_n = DIV_CMP;
        if (cnt == CNT_LAST) begin
`ifdef SIGNED_MULDIV_EN
          if (sgn) state_n = FIXUP;
          else
`endif
          begin
            res_n   = sel ? hi_n : lo_n;
            state_n = DONE;
          end
        end
      end
`ifdef SIGNED_MULDIV_EN
      FIXUP: begin
        if (sel) res_n = neg_r ? alu_resultat : hi;
        else     res_n = neg_q ? alu_resultat : lo;
        state_n = DONE;
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Flush wins over everything, including start and a pending completion.
    if (flush) begin
      state_n = IDLE;
      res_n   = result;
    end
  end

  always_comb begin
    busy_n = 1'b0;
    case (state_n)
      MUL_ADD, DIV_CMP, DIV_SUB: busy_n = 1'b1;
`ifdef SIGNED_MULDIV_EN
      FIXUP:                     busy_n = 1'b1;
`endif
      default:                   busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      sel    <= 1'b0;
      msb    <= 1'b0;
      ge     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef SIGNED_MULDIV_EN
      sgn    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      hi     <= hi_n;
      lo     <= lo_n;
      opnd   <= opnd_n;
      cnt    <= cnt_n;
      sel    <= sel_n;
      msb    <= msb_n;
      ge     <= ge_n;
      busy   <= busy_n;
      done   <= (state_n == DONE);
      result <= res_n;
`ifdef SIGNED_MULDIV_EN
      sgn    <= sgn_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
`endif
    end
  end

endmodule

// File: tb/tb_sequenceur_mul_div.sv
// Bench for sequenceur_mul_div. A behavioural ALU answers the sequencer's
// requests. Expected results and latencies go into a queue at start and are
// popped when done is seen.
module tb_sequenceur_mul_div;

  logic        clk = 1'b0;
  logic        reset_n, start, flush, busy, done, alu_req, alu_source;
  logic [2:0]  op;
  logic [31:0] opa, opb, result, alu_rs1, alu_rs2, alu_resultat;
  logic [4:0]  alu_operation;

  typedef struct { logic [31:0] res; int lat; } exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sequenceur_mul_div dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy), .done(done), .result(result), .alu_req(alu_req),
    .alu_operation(alu_operation), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_source(alu_source), .alu_resultat(alu_resultat)
  );

  always_comb begin
    case (alu_operation)
      5'b00000: alu_resultat = alu_rs1 + alu_rs2;
      5'b01000: alu_resultat = alu_rs1 - alu_rs2;
      5'b10111: alu_resultat = {31'b0, alu_rs1 >= alu_rs2};
      default:  alu_resultat = 32'hDEAD_BEEF;
    endcase
  end

  // Called at a negedge; start is sampled at the next posedge (cycle 0).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int l);
    exp_t e;
    e.res = r; e.lat = l;
    exp_q.push_back(e);
    op = o; opa = a; opb = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom;
  endtask

  // Entered at the negedge of cycle 1; returns the cycle in which done is high.
  task automatic wait_done(output int lat, output int req, output logic bsy, output logic ok);
    lat = 1; req = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (alu_req === 1'b1) req++;
      @(negedge clk);
      lat++;
    end
    ok  = (done === 1'b1);
    bsy = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, alu_req, alu_source} !== 4'b0)
      $display("FAIL reset_ctrl got %b want 0000", {busy, done, alu_req, alu_source}); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else passed++;
    checks++; if ({alu_operation, alu_rs1, alu_rs2} !== 69'd0)
      $display("FAIL reset_alu got op=%b rs1=%h rs2=%h want 0", alu_operation, alu_rs1, alu_rs2); else passed++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int lat, req; logic bsy, ok; exp_t e;
    issue(3'b000, 32'd7, 32'd6, 32'h0000_002A, 33);
    wait_done(lat, req, bsy, ok);
    e = exp_q.pop_front();
    checks++; if (!ok) $display("FAIL mul_timeout no done after %0d cycles", lat); else passed++;
    checks++; if (lat !== e.lat) $display("FAIL mul_latency got %0d want %0d", lat, e.lat); else passed++;
    checks++; if (result !== e.res) $display("FAIL mul_result got %h want %h", result, e.res); else passed++;
    checks++; if (req !== 32) $display("FAIL mul_alu_req got %0d cycles want 32", req); else passed++;
    checks++; if (bsy !== 1'b0 || alu_req !== 1'b0)
      $display("FAIL mul_done_cycle got busy=%b alu_req=%b want 0 0", bsy, alu_req); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL mul_done_pulse got %b want 0", done); else passed++;
  endtask

  task automatic test_mulhu();
    int lat, req; logic bsy, ok; exp_t e;
    logic [31:0] a, b, r; logic [63:0] p; logic [2:0] o;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      begin o = 3'b001; a = '1; b = '1; end
      else if (i == 1) begin o = 3'b000; a = '1; b = '1; end
      else begin o = {2'b00, 1'($urandom_range(0, 1))}; a = $urandom; b = $urandom; end
      p = {32'b0, a} * {32'b0, b};
      r = o[0] ? p[63:32] : p[31:0];
      issue(o, a, b, r, 33);
      wait_done(lat, req, bsy, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || lat !== e.lat)
        $display("FAIL mul%0d_latency got %0d want %0d", i, lat, e.lat); else passed++;
      checks++; if (result !== e.res)
        $display("FAIL mul%0d_result op=%b a=%h b=%h got %h want %h", i, o, a, b, result, e.res); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_divu();
    int lat, req; logic bsy, ok; exp_t e;
    logic [31:0] a, b, r; logic [2:0] o;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin o = 3'b010; a = 32'd100;  b = 32'd7; end
        1: begin o = 3'b011; a = 32'd100;  b = 32'd7; end
        2: begin o = 3'b010; a = '1;       b = 32'h8000_0000; end
        3: begin o = 3'b011; a = '1;       b = 32'h8000_0000; end
        default: begin
          o = {2'b01, 1'($urandom_range(0, 1))}; a = $urandom;
          b = $urandom >> $urandom_range(0, 31);
          if (b == 0) b = 32'd3;
        end
      endcase
      r = o[0] ? (a % b) : (a / b);
      issue(o, a, b, r, 65);
      wait_done(lat, req, bsy, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || lat !== e.lat)
        $display("FAIL div%0d_latency got %0d want %0d", i, lat, e.lat); else passed++;
      checks++; if (result !== e.res)
        $display("FAIL div%0d_result op=%b a=%h b=%h got %h want %h", i, o, a, b, result, e.res); else passed++;
      if (i == 0) begin
        checks++; if (req !== 64) $display("FAIL div_alu_req got %0d cycles want 64", req); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat, req; logic bsy, ok; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(i == 0 ? 3'b010 : 3'b011, 32'd5, 32'd0, i == 0 ? 32'hFFFF_FFFF : 32'd5, 1);
      wait_done(lat, req, bsy, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || lat !== e.lat)
        $display("FAIL divzero%0d_latency got %0d want %0d", i, lat, e.lat); else passed++;
      checks++; if (result !== e.res)
        $display("FAIL divzero%0d_result got %h want %h", i, result, e.res); else passed++;
      checks++; if (alu_req !== 1'b0 || busy !== 1'b0)
        $display("FAIL divzero%0d_ctrl got alu_req=%b busy=%b want 0 0", i, alu_req, busy); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_signed();
    int lat, req; logic bsy, ok; exp_t e;
    logic [2:0] o[5]; logic [31:0] a[5], b[5], r[5]; int l[5];
`ifdef SIGNED_MULDIV_EN
    o[0] = 3'b100; a[0] = 32'hFFFF_FFF9; b[0] = 32'd2;         r[0] = 32'hFFFF_FFFD; l[0] = 66;
    o[1] = 3'b101; a[1] = 32'hFFFF_FFF9; b[1] = 32'd2;         r[1] = 32'hFFFF_FFFF; l[1] = 66;
    o[2] = 3'b100; a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF; r[2] = 32'h8000_0000; l[2] = 1;
    o[3] = 3'b101; a[3] = 32'd7;         b[3] = 32'hFFFF_FFFE; r[3] = 32'd1;         l[3] = 66;
    o[4] = 3'b100; a[4] = 32'd9;         b[4] = 32'd0;         r[4] = 32'hFFFF_FFFF; l[4] = 1;
`else
    for (int i = 0; i < 5; i++) begin
      o[i] = (i % 2 == 0) ? 3'b100 : 3'b101; a[i] = 32'd9 + i; b[i] = 32'd3; r[i] = 32'd0; l[i] = 1;
    end
`endif
    for (int i = 0; i < 5; i++) begin
      issue(o[i], a[i], b[i], r[i], l[i]);
      wait_done(lat, req, bsy, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || lat !== e.lat)
        $display("FAIL signed%0d_latency got %0d want %0d", i, lat, e.lat); else passed++;
      checks++; if (result !== e.res)
        $display("FAIL signed%0d_result got %h want %h", i, result, e.res); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat, req; logic bsy, ok; exp_t e;
    issue(3'b010, 32'd1000, 32'd10, 32'd100, 65);
    wait_done(lat, req, bsy, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || result !== e.res || lat !== e.lat)
      $display("FAIL b2b_first got %h@%0d want %h@%0d", result, lat, e.res, e.lat); else passed++;
    // start raised during the DONE cycle is not an IDLE sample and is dropped
    start = 1'b1; op = 3'b000;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_start_in_done got busy=%b want 0", busy); else passed++;
    issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 33);
    wait_done(lat, req, bsy, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || result !== e.res || lat !== e.lat)
      $display("FAIL b2b_second got %h@%0d want %h@%0d", result, lat, e.res, e.lat); else passed++;
    @(negedge clk);
  endtask

  task automatic test_busy_flush();
    logic [31:0] saved; int dones;
    saved = result; dones = 0;
    op = 3'b000; opa = 32'd3; opb = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk) if (done === 1'b1) dones++;
    op = 3'b010; opa = 32'd9; opb = 32'd0; start = 1'b1;   // ignored while busy
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL start_while_busy got busy=%b done=%b want 1 0", busy, done); else passed++;
    repeat (10) @(negedge clk) if (done === 1'b1) dones++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || alu_req !== 1'b0)
      $display("FAIL flush_idle got busy=%b alu_req=%b want 0 0", busy, alu_req); else passed++;
    repeat (40) @(negedge clk) if (done === 1'b1) dones++;
    checks++; if (dones !== 0) $display("FAIL flush_no_done got %0d done pulses want 0", dones); else passed++;
    checks++; if (result !== saved) $display("FAIL flush_result got %h want %h", result, saved); else passed++;
  endtask

  task automatic test_flush_at_done();
    logic [31:0] saved;
    saved = result;
    op = 3'b000; opa = 32'd11; opb = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);    // cycle 32: last multiply step
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (done !== 1'b0 || result !== saved)
      $display("FAIL flush_last_step got done=%b result=%h want 0 %h", done, result, saved); else passed++;
    flush = 1'b1; start = 1'b1; op = 3'b010; opa = 32'd4; opb = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++; if (done !== 1'b0 || result !== saved)
      $display("FAIL flush_over_start got done=%b result=%h want 0 %h", done, result, saved); else passed++;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    op = 3'b010; opa = 32'd500; opb = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, done, alu_req, alu_source} !== 4'b0 || result !== 32'h0)
      $display("FAIL reset_mid_ctrl got %b result=%h want 0000 0", {busy, done, alu_req, alu_source}, result); else passed++;
    checks++; if ({alu_operation, alu_rs1, alu_rs2} !== 69'd0)
      $display("FAIL reset_mid_alu got op=%b rs1=%h rs2=%h want 0", alu_operation, alu_rs1, alu_rs2); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (70) @(negedge clk) if (done === 1'b1) dones++;
    checks++; if (dones !== 0) $display("FAIL reset_mid_no_done got %0d want 0", dones); else passed++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_mulhu();
    test_divu();
    test_div_zero();
    test_signed();
    test_back_to_back();
    test_busy_flush();
    test_flush_at_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
